// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared constants and FSM state type for the ID/EX pipeline stage
// Purpose : common definitions imported by id_ex_stage and load_use_detect.
// Contents: ZERO/ONE bit constants, CTRL_W default, RUN/STALL state encoding.
package id_ex_stage_pkg;

    localparam logic ZERO           = 1'b0;
    localparam logic ONE            = 1'b1;
    localparam int   CTRL_W_DEFAULT = 12;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_e;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// rtl/id_ex_stage_load_use_detect.sv - combinational load-use hazard compare
// Purpose : flags an instruction in ID that reads the destination of a load in EX.
// Ports   : ex_valid/ex_mem_read/ex_rd   - load currently held in ID/EX
//           id_valid/id_uses_rs*/id_rs*   - instruction currently in IF/ID
//           hazard                        - 1 when a bubble must be inserted
module load_use_detect
    import id_ex_stage_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic       id_valid,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    output logic       hazard
);

    logic rd_live;
    logic rs1_hit;
    logic rs2_hit;

    // x0 is hardwired zero, so a load targeting it never produces a value to wait for.
    assign rd_live = (ex_rd != 5'd0);
    // Register fields are only meaningful when the instruction actually reads them.
    assign rs1_hit = id_uses_rs1 & (ex_rd == id_rs1);
    assign rs2_hit = id_uses_rs2 & (ex_rd == id_rs2);

    assign hazard = (ex_valid & ex_mem_read & rd_live & id_valid & (rs1_hit | rs2_hit)) ? ONE : ZERO;

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall FSM
// Purpose : registers decoded fields into EX, inserts one bubble per load-use pair,
//           squashes on EX redirect, and counts hazard bubbles (saturating).
// Ports   : clk, rst (async, active-high)
//           IF_ID_*/id_* - decode-stage fields;  ex_flush - EX redirect
//           ID_EX_*      - registered EX-stage fields
//           stall        - combinational hold for PC and IF/ID
//           stall_count  - saturating number of hazard bubbles
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = CTRL_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        IF_ID_RegisterRs1,
    input  logic [4:0]        IF_ID_RegisterRs2,
    input  logic [4:0]        IF_ID_RegisterRd,
    input  logic              id_UsesRs1,
    input  logic              id_UsesRs2,
    input  logic              id_RegWrite,
    input  logic              id_MemRead,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              ex_flush,
    output logic [4:0]        ID_EX_RegisterRs1,
    output logic [4:0]        ID_EX_RegisterRs2,
    output logic [4:0]        ID_EX_RegisterRd,
    output logic              ID_EX_RegWrite,
    output logic              ID_EX_MemRead,
    output logic              ID_EX_valid,
    output logic [XLEN-1:0]   ID_EX_pc,
    output logic [XLEN-1:0]   ID_EX_rs1_data,
    output logic [XLEN-1:0]   ID_EX_rs2_data,
    output logic [XLEN-1:0]   ID_EX_imm,
    output logic [CTRL_W-1:0] ID_EX_ctrl,
    output logic              stall,
    output logic [15:0]       stall_count
);

    state_e            state_q, state_d;
    logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q, mem_read_d;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   pc_q, pc_d, rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]   rs2_data_q, rs2_data_d, imm_q, imm_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [15:0]       stall_count_q, stall_count_d;
    logic              hazard;
    logic              stall_c;

    load_use_detect u_detect (
        .ex_valid    (valid_q),
        .ex_mem_read (mem_read_q),
        .ex_rd       (rd_q),
        .id_valid    (id_valid),
        .id_uses_rs1 (id_UsesRs1),
        .id_uses_rs2 (id_UsesRs2),
        .id_rs1      (IF_ID_RegisterRs1),
        .id_rs2      (IF_ID_RegisterRs2),
        .hazard      (hazard)
    );

    always_comb begin
        // A redirect squashes the decode instruction anyway, so it outranks the hazard.
        // In STALL, EX already holds a bubble, so the held instruction is hazard-free.
        stall_c       = (state_q == RUN) & hazard & ~ex_flush;
        state_d       = stall_c ? STALL : RUN;
        stall_count_d = (stall_c && stall_count_q != 16'hFFFF) ? stall_count_q + 16'd1
                                                               : stall_count_q;
        rs1_d         = rs1_q;
        rs2_d         = rs2_q;
        rd_d          = rd_q;
        reg_write_d   = reg_write_q;
        mem_read_d    = mem_read_q;
        valid_d       = valid_q;
        pc_d          = pc_q;
        rs1_data_d    = rs1_data_q;
        rs2_data_d    = rs2_data_q;
        imm_d         = imm_q;
        ctrl_d        = ctrl_q;
        if (ex_flush || stall_c || !id_valid) begin
            // Bubble: kill every side-effecting field; data fields simply hold.
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            ctrl_d      = '0;
            rd_d        = 5'd0;
        end else begin
            rs1_d       = IF_ID_RegisterRs1;
            rs2_d       = IF_ID_RegisterRs2;
            rd_d        = IF_ID_RegisterRd;
            reg_write_d = id_RegWrite;
            mem_read_d  = id_MemRead;
            valid_d     = 1'b1;
            pc_d        = id_pc;
            rs1_data_d  = id_rs1_data;
            rs2_data_d  = id_rs2_data;
            imm_d       = id_imm;
            ctrl_d      = id_ctrl;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            rs1_q         <= '0;
            rs2_q         <= '0;
            rd_q          <= '0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            valid_q       <= 1'b0;
            pc_q          <= '0;
            rs1_data_q    <= '0;
            rs2_data_q    <= '0;
            imm_q         <= '0;
            ctrl_q        <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            rd_q          <= rd_d;
            reg_write_q   <= reg_write_d;
            mem_read_q    <= mem_read_d;
            valid_q       <= valid_d;
            pc_q          <= pc_d;
            rs1_data_q    <= rs1_data_d;
            rs2_data_q    <= rs2_data_d;
            imm_q         <= imm_d;
            ctrl_q        <= ctrl_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign ID_EX_RegisterRs1 = rs1_q;
    assign ID_EX_RegisterRs2 = rs2_q;
    assign ID_EX_RegisterRd  = rd_q;
    assign ID_EX_RegWrite    = reg_write_q;
    assign ID_EX_MemRead     = mem_read_q;
    assign ID_EX_valid       = valid_q;
    assign ID_EX_pc          = pc_q;
    assign ID_EX_rs1_data    = rs1_data_q;
    assign ID_EX_rs2_data    = rs2_data_q;
    assign ID_EX_imm         = imm_q;
    assign ID_EX_ctrl        = ctrl_q;
    assign stall             = stall_c;
    assign stall_count       = stall_count_q;

endmodule
